// File: rtl/seq_restoring_divider_if.sv
// seq_restoring_divider_if: operand/result handshake bundle for the sequential divider.
interface seq_restoring_divider_if #(parameter int W = 4);
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         dz_err;
    modport master(output start, dividend, divisor, input quotient, remainder, busy, done, dz_err);
    modport slave(input start, dividend, divisor, output quotient, remainder, busy, done, dz_err);
endinterface

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: unsigned restoring divider, one quotient bit per RUN cycle.
module seq_restoring_divider #(parameter int W = 4) (
    input logic clk,
    input logic rst,
    seq_restoring_divider_if.slave bus
);
    localparam int CW = $clog2(W + 1);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state_q, state_d;
    logic [W:0] sh_pr, trial;
    logic [W-1:0] pr_q, pr_d, wq_q, wq_d, dvs_q, dvs_d, quo_q, quo_d, rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic busy_q, done_q, dz_q, dz_d, accept;
    // The partial remainder never exceeds the divisor, so W bits suffice; only the trial needs W+1.
    always_comb begin
        accept = bus.start && state_q != RUN;
        sh_pr = {pr_q, wq_q[W-1]};
        trial = sh_pr - {1'b0, dvs_q};
        state_d = state_q;
        pr_d = pr_q;
        wq_d = wq_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        quo_d = quo_q;
        rem_d = rem_q;
        dz_d = dz_q;
        if (accept) begin
            dvs_d = bus.divisor;
            wq_d = bus.dividend;
            pr_d = '0;
            cnt_d = CW'(W);
            dz_d = bus.divisor == '0;
            state_d = dz_d ? FIN : RUN;
            quo_d = dz_d ? '1 : quo_q;
            rem_d = dz_d ? bus.dividend : rem_q;
        end else if (state_q == RUN) begin
            pr_d = trial[W] ? sh_pr[W-1:0] : trial[W-1:0];
            wq_d = {wq_q[W-2:0], ~trial[W]};
            cnt_d = cnt_q - CW'(1);
            state_d = cnt_q == CW'(1) ? FIN : RUN;
            quo_d = cnt_q == CW'(1) ? wq_d : quo_q;
            rem_d = cnt_q == CW'(1) ? pr_d : rem_q;
        end else if (state_q == FIN) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pr_q <= '0;
            wq_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dz_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pr_q <= pr_d;
            wq_q <= wq_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
            dz_q <= dz_d;
            busy_q <= state_q == RUN;
            done_q <= state_q == FIN;
        end
    end
    assign bus.quotient = quo_q;
    assign bus.remainder = rem_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dz_err = dz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed checks of latency, results, reset and start handling.
module tb_seq_restoring_divider;
    localparam int W = 4;
    logic clk = 1'b0;
    logic rst;
    int tests = 0;
    int failed = 0;
    seq_restoring_divider_if #(.W(W)) bus();
    seq_restoring_divider #(.W(W)) dut(.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic wait_done(output int n, output int nb);
        n = 0;
        nb = 0;
        while (bus.done !== 1'b1 && n < 30) begin
            nb += int'(bus.busy === 1'b1);
            n++;
            @(negedge clk);
        end
    endtask
    task automatic check_zero(input string tag);
        check({tag, ".q"}, 32'(bus.quotient), 0);
        check({tag, ".r"}, 32'(bus.remainder), 0);
        check({tag, ".busy"}, 32'(bus.busy), 0);
        check({tag, ".done"}, 32'(bus.done), 0);
        check({tag, ".dz"}, 32'(bus.dz_err), 0);
    endtask
    task automatic divide(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input string tag);
        int n, nb;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = a;
        bus.divisor = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.dividend = ~a;
        bus.divisor = ~b;
        wait_done(n, nb);
        check({tag, ".lat"}, 32'(n), b == '0 ? 1 : W + 1);
        check({tag, ".nbusy"}, 32'(nb), b == '0 ? 0 : W);
        check({tag, ".q"}, 32'(bus.quotient), 32'(eq));
        check({tag, ".r"}, 32'(bus.remainder), 32'(er));
        check({tag, ".dz"}, 32'(bus.dz_err), 32'(b == '0));
        check({tag, ".ovl"}, 32'(bus.busy), 0);
        @(negedge clk);
        check({tag, ".pulse"}, 32'(bus.done), 0);
    endtask
    initial begin
        int n, nb, nd;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        bus.start = 1'b1;
        bus.dividend = 4'd13;
        bus.divisor = 4'd4;
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("rst_start.busy", 32'(bus.busy), 0);
        check("rst_start.done", 32'(bus.done), 0);
        divide(4'd13, 4'd4, 4'd3, 4'd1, "13/4");
        divide(4'd15, 4'd1, 4'd15, 4'd0, "15/1");
        divide(4'd3, 4'd7, 4'd0, 4'd3, "3/7");
        divide(4'd0, 4'd5, 4'd0, 4'd0, "0/5");
        divide(4'd9, 4'd0, 4'd15, 4'd9, "9/0");
        divide(4'd10, 4'd3, 4'd3, 4'd1, "10/3");
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 4'd12;
        bus.divisor = 4'd5;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 4'd6;
        bus.divisor = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(n, nb);
        check("ignore.lat", 32'(n), 3);
        check("ignore.q", 32'(bus.quotient), 2);
        check("ignore.r", 32'(bus.remainder), 2);
        nd = 0;
        repeat (10) begin
            @(negedge clk);
            nd += int'(bus.done === 1'b1 || bus.busy === 1'b1);
        end
        check("ignore.noqueue", 32'(nd), 0);
        bus.start = 1'b1;
        bus.dividend = 4'd14;
        bus.divisor = 4'd3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort.busy", 32'(bus.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check_zero("abort");
        rst = 1'b0;
        nd = 0;
        repeat (10) begin
            @(negedge clk);
            nd += int'(bus.done === 1'b1);
        end
        check("abort.nodone", 32'(nd), 0);
        divide(4'd14, 4'd3, 4'd4, 4'd2, "14/3");
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 4'd13;
        bus.divisor = 4'd4;
        @(negedge clk);
        bus.dividend = 4'd7;
        bus.divisor = 4'd2;
        wait_done(n, nb);
        check("b2b1.lat", 32'(n), W + 1);
        check("b2b1.q", 32'(bus.quotient), 3);
        check("b2b1.r", 32'(bus.remainder), 1);
        bus.start = 1'b0;
        @(negedge clk);
        check("b2b.noidle", 32'(bus.busy), 1);
        check("b2b.pulse", 32'(bus.done), 0);
        wait_done(n, nb);
        check("b2b2.lat", 32'(n), W);
        check("b2b2.q", 32'(bus.quotient), 3);
        check("b2b2.r", 32'(bus.remainder), 1);
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                divide(4'(a), 4'(b), b == 0 ? 4'hf : 4'(a / b), b == 0 ? 4'(a) : 4'(a % b), "sweep");
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
